// File: rtl/fifo_rd_ctrl_if.sv
// Bundle between the FIFO read controller, its FIFO and the shared-memory arbiter.
// master: the controller side; slave: the FIFO/arbiter environment side.
interface fifo_rd_ctrl_if #(
    parameter int FIFO_PTR   = 4,
    parameter int FIFO_WIDTH = 32
);
    logic                  empty;
    logic [FIFO_PTR:0]     data_avail;
    logic [FIFO_WIDTH-1:0] read_data;
    logic                  read_en;
    logic                  gnt;
    logic                  flush;
    logic                  req;
    logic [FIFO_WIDTH-1:0] req_data;
    logic                  busy;
    logic [15:0]           xfer_cnt;

    modport master (
        input  empty, data_avail, read_data, gnt, flush,
        output read_en, req, req_data, busy, xfer_cnt
    );

    modport slave (
        output empty, data_avail, read_data, gnt, flush,
        input  read_en, req, req_data, busy, xfer_cnt
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: pops one word at a time, holds it and presents it to the
// shared-memory arbiter until granted; inserts a one-cycle gap after BURST_MAX
// consecutive grants so other requesters get a turn.
//
// state | meaning
// IDLE  | waiting for the FIFO to become non-empty
// POP   | read_en high for this single cycle
// LOAD  | FIFO word valid on read_data, captured into the hold register
// REQ   | req high with the held word until gnt
// GAP   | forced one-cycle release after a full burst
module fifo_rd_ctrl #(
    parameter int FIFO_PTR   = 4,
    parameter int FIFO_WIDTH = 32,
    parameter int BURST_MAX  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_rd_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POP  = 3'd1,
        S_LOAD = 3'd2,
        S_REQ  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t                state_q, state_d;
    logic [FIFO_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [15:0]           xfer_cnt_q, xfer_cnt_d;
    logic [3:0]            burst_cnt_q, burst_cnt_d;
    logic [3:0]            burst_inc;

    // Occupancy is status only; it never steers the controller.
    logic [FIFO_PTR:0]     unused_data_avail;
    assign unused_data_avail = bus.data_avail;

    // State and datapath registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_data_q <= '0;
            xfer_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            xfer_cnt_q  <= xfer_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state logic; flush outranks everything, including a same-cycle grant.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        xfer_cnt_d  = xfer_cnt_q;
        burst_cnt_d = burst_cnt_q;
        burst_inc   = burst_cnt_q + 4'd1;

        if (bus.flush) begin
            state_d     = S_IDLE;
            burst_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.empty) begin
                        state_d = S_POP;
                    end
                end
                S_POP: begin
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    hold_data_d = bus.read_data;
                    state_d     = S_REQ;
                end
                S_REQ: begin
                    if (bus.gnt) begin
                        xfer_cnt_d = xfer_cnt_q + 16'd1;
                        if (burst_inc == BURST_LIM) begin
                            burst_cnt_d = '0;
                            state_d     = S_GAP;
                        end else if (!bus.empty) begin
                            burst_cnt_d = burst_inc;
                            state_d     = S_POP;
                        end else begin
                            burst_cnt_d = '0;
                            state_d     = S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state or driven straight from flops.
    assign bus.read_en  = (state_q == S_POP);
    assign bus.req      = (state_q == S_REQ);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.req_data = hold_data_q;
    assign bus.xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a small behavioural FIFO model.
module tb_fifo_rd_ctrl;

    logic clk;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic [31:0] fifo_q[$];

    fifo_rd_ctrl_if #(.FIFO_PTR(4), .FIFO_WIDTH(32)) bus ();

    fifo_rd_ctrl #(.FIFO_PTR(4), .FIFO_WIDTH(32), .BURST_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; FIFO model pops on a sampled read_en, data valid next cycle.
    task automatic step();
        logic re;
        re = bus.read_en;
        @(posedge clk);
        #1;
        if (re) begin
            total_cnt++;
            if (fifo_q.size() == 0) begin
                $display("FAIL pop_on_empty: read_en=1 sampled, fifo size %0d required >0", fifo_q.size());
            end else begin
                pass_cnt++;
                bus.read_data = fifo_q.pop_front();
            end
        end
        bus.empty      = (fifo_q.size() == 0);
        bus.data_avail = 5'(fifo_q.size());
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        bus.empty      = 1'b0;
        bus.data_avail = 5'(fifo_q.size());
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.gnt        = 1'b0;
        bus.flush      = 1'b0;
        bus.empty      = 1'b1;
        bus.data_avail = '0;
        bus.read_data  = '0;
        #1;
        total_cnt++;
        if ({bus.read_en, bus.req, bus.busy} !== 3'b000)
            $display("FAIL reset_ctrl: got %b required 000", {bus.read_en, bus.req, bus.busy});
        else pass_cnt++;
        total_cnt++;
        if (bus.req_data !== 32'h0)
            $display("FAIL reset_req_data: got %h required 00000000", bus.req_data);
        else pass_cnt++;
        total_cnt++;
        if (bus.xfer_cnt !== 16'h0)
            $display("FAIL reset_xfer_cnt: got %h required 0000", bus.xfer_cnt);
        else pass_cnt++;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        total_cnt++;
        if (bus.busy !== 1'b0)
            $display("FAIL idle_when_empty: busy got %b required 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_single_word();
        int n_re, n_req, i_re, i_req;
        logic [31:0] d;
        n_re = 0; n_req = 0; i_re = -1; i_req = -1; d = '0;
        bus.gnt = 1'b1;
        push(32'hFFFF_FFFE);
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.read_en) begin n_re++; if (i_re < 0) i_re = i; end
            if (bus.req) begin
                n_req++;
                if (i_req < 0) begin i_req = i; d = bus.req_data; end
            end
        end
        total_cnt++;
        if (n_re != 1) $display("FAIL single_read_en_pulses: got %0d required 1", n_re);
        else pass_cnt++;
        total_cnt++;
        if (n_req != 1) $display("FAIL single_req_cycles: got %0d required 1", n_req);
        else pass_cnt++;
        total_cnt++;
        if (i_req - i_re != 2) $display("FAIL single_req_latency: got %0d required 2", i_req - i_re);
        else pass_cnt++;
        total_cnt++;
        if (d !== 32'hFFFF_FFFE) $display("FAIL single_req_data: got %h required fffffffe", d);
        else pass_cnt++;
        total_cnt++;
        if (bus.xfer_cnt !== 16'd1) $display("FAIL single_xfer_cnt: got %0d required 1", bus.xfer_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL single_back_idle: busy got %b required 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_grant_stall();
        int n_re, n_req, bad;
        n_re = 0; n_req = 0; bad = 0;
        bus.gnt = 1'b0;
        push(32'hFFFF_FFFD);
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.read_en) n_re++;
            if (bus.req) begin
                n_req++;
                if (bus.req_data !== 32'hFFFF_FFFD) bad++;
            end
            bus.gnt = (n_req >= 6);
        end
        total_cnt++;
        if (n_req != 6) $display("FAIL stall_req_cycles: got %0d required 6", n_req);
        else pass_cnt++;
        total_cnt++;
        if (n_re != 1) $display("FAIL stall_read_en_pulses: got %0d required 1", n_re);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0) $display("FAIL stall_data_stable: got %0d bad cycles required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (bus.xfer_cnt !== 16'd2) $display("FAIL stall_xfer_cnt: got %0d required 2", bus.xfer_cnt);
        else pass_cnt++;
    endtask

    task automatic test_burst_limit();
        int n_re, n_got, bad, n_gap, gap_after, last_i, spacing_bad;
        logic prev_req;
        n_re = 0; n_got = 0; bad = 0; n_gap = 0; gap_after = -1; last_i = -1;
        spacing_bad = 0; prev_req = 1'b0;
        bus.gnt = 1'b1;
        for (int k = 0; k < 6; k++) push(32'hFFFF_FFFE - 32'(k));
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.read_en) n_re++;
            if (bus.req) begin
                if (bus.req_data !== 32'hFFFF_FFFE - 32'(n_got)) bad++;
                if (n_got >= 1 && n_got <= 3 && (i - last_i) != 3) spacing_bad++;
                last_i = i;
                n_got++;
            end
            if (prev_req && bus.busy && !bus.req && !bus.read_en) begin
                n_gap++;
                gap_after = n_got;
            end
            prev_req = bus.req;
        end
        total_cnt++;
        if (n_got != 6) $display("FAIL burst_words: got %0d required 6", n_got);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0) $display("FAIL burst_order: got %0d bad words required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (n_gap != 1) $display("FAIL burst_gap_count: got %0d required 1", n_gap);
        else pass_cnt++;
        total_cnt++;
        if (gap_after != 4) $display("FAIL burst_gap_position: got %0d required 4", gap_after);
        else pass_cnt++;
        total_cnt++;
        if (spacing_bad != 0) $display("FAIL burst_spacing: got %0d bad gaps required 0", spacing_bad);
        else pass_cnt++;
        total_cnt++;
        if (n_re != 6) $display("FAIL burst_pops: got %0d required 6", n_re);
        else pass_cnt++;
        total_cnt++;
        if (bus.xfer_cnt !== 16'd8) $display("FAIL burst_xfer_cnt: got %0d required 8", bus.xfer_cnt);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic found;
        int n_act, n_req;
        logic [31:0] d;
        found = 1'b0;
        bus.gnt = 1'b0;
        push(32'h1234_5678);
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = bus.req;
        end
        total_cnt++;
        if (!found) $display("FAIL flush_reach_req: req got 0 within 10 cycles required 1");
        else pass_cnt++;
        bus.gnt   = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        total_cnt++;
        if ({bus.req, bus.busy} !== 2'b00)
            $display("FAIL flush_to_idle: req,busy got %b required 00", {bus.req, bus.busy});
        else pass_cnt++;
        total_cnt++;
        if (bus.xfer_cnt !== 16'd8) $display("FAIL flush_xfer_cnt: got %0d required 8", bus.xfer_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.req_data !== 32'h1234_5678)
            $display("FAIL flush_req_data_hold: got %h required 12345678", bus.req_data);
        else pass_cnt++;
        n_act = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.req || bus.read_en) n_act++;
        end
        total_cnt++;
        if (n_act != 0 || bus.xfer_cnt !== 16'd8)
            $display("FAIL flush_word_dropped: activity %0d xfer %0d required 0 and 8", n_act, bus.xfer_cnt);
        else pass_cnt++;

        push(32'hAAAA_0001);
        push(32'hAAAA_0002);
        step();
        total_cnt++;
        if (bus.read_en !== 1'b1) $display("FAIL flush_pop_entry: read_en got %b required 1", bus.read_en);
        else pass_cnt++;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL flush_in_pop: busy got %b required 0", bus.busy);
        else pass_cnt++;
        n_req = 0; d = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.req) begin n_req++; d = bus.req_data; end
        end
        total_cnt++;
        if (n_req != 1 || d !== 32'hAAAA_0002)
            $display("FAIL flush_next_word: req %0d data %h required 1 and aaaa0002", n_req, d);
        else pass_cnt++;
        total_cnt++;
        if (bus.xfer_cnt !== 16'd9) $display("FAIL flush_after_xfer_cnt: got %0d required 9", bus.xfer_cnt);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic found;
        int n_act, n_req;
        logic [31:0] d;
        found = 1'b0;
        bus.gnt = 1'b0;
        push(32'hCAFE_0001);
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = bus.req;
        end
        total_cnt++;
        if (!found) $display("FAIL areset_reach_req: req got 0 within 10 cycles required 1");
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.req, bus.busy} !== 2'b00)
            $display("FAIL areset_req_now: req,busy got %b required 00", {bus.req, bus.busy});
        else pass_cnt++;
        total_cnt++;
        if (bus.xfer_cnt !== 16'd0 || bus.req_data !== 32'h0)
            $display("FAIL areset_regs_now: xfer %0d data %h required 0 and 0", bus.xfer_cnt, bus.req_data);
        else pass_cnt++;
        #1;
        rst_n = 1'b1;
        bus.gnt = 1'b1;
        n_act = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.req || bus.read_en) n_act++;
        end
        total_cnt++;
        if (n_act != 0) $display("FAIL areset_quiet_when_empty: activity got %0d required 0", n_act);
        else pass_cnt++;
        push(32'hCAFE_0002);
        step();
        total_cnt++;
        if (bus.read_en !== 1'b1) $display("FAIL areset_first_pop: read_en got %b required 1", bus.read_en);
        else pass_cnt++;
        n_req = 0; d = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.req) begin n_req++; d = bus.req_data; end
        end
        total_cnt++;
        if (n_req != 1 || d !== 32'hCAFE_0002 || bus.xfer_cnt !== 16'd1)
            $display("FAIL areset_resume: req %0d data %h xfer %0d required 1 cafe0002 1", n_req, d, bus.xfer_cnt);
        else pass_cnt++;
    endtask

    task automatic test_counter_wrap();
        logic seen;
        force dut.xfer_cnt_q = 16'hFFFF;
        step();
        release dut.xfer_cnt_q;
        #1;
        total_cnt++;
        if (bus.xfer_cnt !== 16'hFFFF) $display("FAIL wrap_preload: got %h required ffff", bus.xfer_cnt);
        else pass_cnt++;
        bus.gnt = 1'b1;
        push(32'hBEEF_0001);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.req && bus.req_data === 32'hBEEF_0001) seen = 1'b1;
        end
        total_cnt++;
        if (!seen) $display("FAIL wrap_word_req: req with beef0001 got 0 required 1");
        else pass_cnt++;
        total_cnt++;
        if (bus.xfer_cnt !== 16'h0000) $display("FAIL wrap_xfer_cnt: got %h required 0000", bus.xfer_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_grant_stall();
        test_burst_limit();
        test_flush();
        test_async_reset();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
